// File: rtl/sp_ram_arb2.sv
// sp_ram_arb2: two-master round-robin arbiter in front of a single-port RAM.
// Accepts req/gnt/rvalid transactions from two masters. It issues at most one
// RAM access per cycle and routes the one-cycle-latency read data back to the
// master that issued the access. It also counts contention stalls, saturating
// at all-ones.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   pN_req_i/gnt_o                 request / same-cycle grant, N = 0, 1
//   pN_addr_i/we_i/be_i/wdata_i    request fields
//   pN_rvalid_o/rdata_o            response; rdata is zero for writes
//   ram_en_o/addr_o/we_o/be_o/wdata_o, ram_rdata_i   RAM port
//   stall_cnt_o                    saturating count of stalled cycles
module sp_ram_arb2 #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    p0_req_i,
  output logic                    p0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  input  logic                    p0_we_i,
  input  logic [DATA_WIDTH/8-1:0] p0_be_i,
  input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
  output logic                    p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,
  input  logic                    p1_req_i,
  output logic                    p1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic                    p1_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  output logic                    p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
  output logic [15:0]             stall_cnt_o
);

  localparam int unsigned CNT_WIDTH = 16;

  logic                 prio_q, prio_d;
  logic                 resp_vld_q, resp_vld_d;
  logic                 resp_port_q, resp_port_d;
  logic                 resp_rd_q, resp_rd_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic                 gnt0_c, gnt1_c, stall_c;

  // Same-cycle arbitration; prio_q breaks ties, and reset blocks all grants.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!rst) begin
      if (p0_req_i && (!p1_req_i || !prio_q)) begin
        gnt0_c = 1'b1;
      end else if (p1_req_i) begin
        gnt1_c = 1'b1;
      end
    end
  end

  assign stall_c = (p0_req_i & ~gnt0_c) | (p1_req_i & ~gnt1_c);

  // RAM pins follow the granted port, defaulting to port 0 when idle.
  always_comb begin
    ram_en_o    = gnt0_c | gnt1_c;
    ram_addr_o  = p0_addr_i;
    ram_we_o    = p0_we_i;
    ram_be_o    = p0_be_i;
    ram_wdata_o = p0_wdata_i;
    if (gnt1_c) begin
      ram_addr_o  = p1_addr_i;
      ram_we_o    = p1_we_i;
      ram_be_o    = p1_be_i;
      ram_wdata_o = p1_wdata_i;
    end
  end

  // Next state: priority goes to the loser, and the response tracks the granted access.
  always_comb begin
    prio_d      = prio_q;
    resp_vld_d  = gnt0_c | gnt1_c;
    resp_port_d = gnt1_c;
    resp_rd_d   = ~ram_we_o;
    stall_cnt_d = stall_cnt_q;
    if (gnt0_c) begin
      prio_d = 1'b1;
    end else if (gnt1_c) begin
      prio_d = 1'b0;
    end
    if (stall_c && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q      <= 1'b0;
      resp_vld_q  <= 1'b0;
      resp_port_q <= 1'b0;
      resp_rd_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      prio_q      <= prio_d;
      resp_vld_q  <= resp_vld_d;
      resp_port_q <= resp_port_d;
      resp_rd_q   <= resp_rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign p0_gnt_o    = gnt0_c;
  assign p1_gnt_o    = gnt1_c;
  assign p0_rvalid_o = resp_vld_q & ~resp_port_q;
  assign p1_rvalid_o = resp_vld_q & resp_port_q;
  // Write responses return zero data.
  assign p0_rdata_o  = (p0_rvalid_o && resp_rd_q) ? ram_rdata_i : '0;
  assign p1_rdata_o  = (p1_rvalid_o && resp_rd_q) ? ram_rdata_i : '0;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_sp_ram_arb2.sv
// Directed bench for sp_ram_arb2.
// Inputs change on the falling edge. Outputs are sampled 1 time unit later,
// in the same clock cycle.
module tb_sp_ram_arb2;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p0_req, p0_gnt, p0_we, p0_rvalid;
  logic [AW-1:0] p0_addr;
  logic [3:0]    p0_be;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_req, p1_gnt, p1_we, p1_rvalid;
  logic [AW-1:0] p1_addr;
  logic [3:0]    p1_be;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_be;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [15:0]   stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sp_ram_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .p0_req_i(p0_req), .p0_gnt_o(p0_gnt), .p0_addr_i(p0_addr), .p0_we_i(p0_we),
    .p0_be_i(p0_be), .p0_wdata_i(p0_wdata), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
    .p1_req_i(p1_req), .p1_gnt_o(p1_gnt), .p1_addr_i(p1_addr), .p1_we_i(p1_we),
    .p1_be_i(p1_be), .p1_wdata_i(p1_wdata), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .stall_cnt_o(stall_cnt)
  );

  // RAM model: one-cycle read latency. It returns data on every enabled access,
  // including writes, so a write response that leaks rdata is caught.
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= (ram_addr == 15'h0010) ? 32'hDEADBEEF : (32'hA5A50000 | 32'(ram_addr));
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Advance to the next cycle's input-drive point.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    p0_req = 0; p0_addr = '0; p0_we = 0; p0_be = 4'hF; p0_wdata = '0;
    p1_req = 0; p1_addr = '0; p1_we = 0; p1_be = 4'hF; p1_wdata = '0;
    rst = 1;
    next_cycle(); next_cycle();
    #1;
    check("rst_p0_gnt", 32'(p0_gnt), 32'd0);
    check("rst_p1_gnt", 32'(p1_gnt), 32'd0);
    check("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
    check("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
    check("rst_p0_rdata", p0_rdata, 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);

    // 1: single read from port 0
    next_cycle();
    rst = 0; p0_req = 1; p0_addr = 15'h0010; p0_we = 0;
    #1;
    check("t1_p0_gnt", 32'(p0_gnt), 32'd1);
    check("t1_p1_gnt", 32'(p1_gnt), 32'd0);
    check("t1_ram_en", 32'(ram_en), 32'd1);
    check("t1_ram_addr", 32'(ram_addr), 32'h0010);
    check("t1_ram_we", 32'(ram_we), 32'd0);
    next_cycle();
    p0_req = 0;
    #1;
    check("t1_p0_rvalid", 32'(p0_rvalid), 32'd1);
    check("t1_p0_rdata", p0_rdata, 32'hDEADBEEF);
    check("t1_p1_rvalid", 32'(p1_rvalid), 32'd0);

    // 2: continuous contention after reset
    next_cycle(); rst = 1;
    next_cycle(); rst = 0;
    p0_req = 1; p0_addr = 15'h0100; p1_req = 1; p1_addr = 15'h0200; p1_we = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("t2_p0_gnt_%0d", i), 32'(p0_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("t2_p1_gnt_%0d", i), 32'(p1_gnt), (i % 2 == 0) ? 32'd0 : 32'd1);
      next_cycle();
    end
    p0_req = 0; p1_req = 0;
    #1;
    check("t2_stall", 32'(stall_cnt), 32'd6);
    check("t2_p1_rvalid", 32'(p1_rvalid), 32'd1);
    check("t2_p1_rdata", p1_rdata, 32'hA5A50200);

    // 3: write with byte enables from port 1
    next_cycle();
    p1_req = 1; p1_we = 1; p1_be = 4'b0101; p1_wdata = 32'h11223344; p1_addr = 15'h7FFC;
    #1;
    check("t3_p1_gnt", 32'(p1_gnt), 32'd1);
    check("t3_ram_en", 32'(ram_en), 32'd1);
    check("t3_ram_addr", 32'(ram_addr), 32'h7FFC);
    check("t3_ram_we", 32'(ram_we), 32'd1);
    check("t3_ram_be", 32'(ram_be), 32'h5);
    check("t3_ram_wdata", ram_wdata, 32'h11223344);
    next_cycle();
    p1_req = 0; p1_we = 0; p1_be = 4'hF;
    #1;
    check("t3_p1_rvalid", 32'(p1_rvalid), 32'd1);
    check("t3_p1_rdata", p1_rdata, 32'd0);
    check("t3_p0_rvalid", 32'(p0_rvalid), 32'd0);

    // 4: back-to-back read then write on port 0
    next_cycle();
    p0_req = 1; p0_we = 0; p0_addr = 15'h0020;
    #1;
    check("t4_gnt_a", 32'(p0_gnt), 32'd1);
    next_cycle();
    p0_we = 1; p0_addr = 15'h0024; p0_wdata = 32'hCAFEF00D;
    #1;
    check("t4_gnt_b", 32'(p0_gnt), 32'd1);
    check("t4_ram_wdata", ram_wdata, 32'hCAFEF00D);
    check("t4_rvalid_a", 32'(p0_rvalid), 32'd1);
    check("t4_rdata_a", p0_rdata, 32'hA5A50020);
    next_cycle();
    p0_req = 0; p0_we = 0;
    #1;
    check("t4_rvalid_b", 32'(p0_rvalid), 32'd1);
    check("t4_rdata_b", p0_rdata, 32'd0);
    check("t4_stall_kept", 32'(stall_cnt), 32'd6);

    // 5: reset mid-flight with p1 request held
    next_cycle();
    p0_req = 1; p0_addr = 15'h0010;
    #1;
    check("t5_p0_gnt", 32'(p0_gnt), 32'd1);
    next_cycle();
    rst = 1; p0_req = 0; p1_req = 1; p1_addr = 15'h0030;
    #1;
    check("t5_p0_rvalid", 32'(p0_rvalid), 32'd1);
    check("t5_p0_rdata", p0_rdata, 32'hDEADBEEF);
    check("t5_p1_gnt_rst", 32'(p1_gnt), 32'd0);
    check("t5_ram_en_rst", 32'(ram_en), 32'd0);
    check("t5_stall_pre", 32'(stall_cnt), 32'd6);
    next_cycle();
    rst = 0;
    #1;
    check("t5_p1_gnt", 32'(p1_gnt), 32'd1);
    check("t5_p0_rvalid_clr", 32'(p0_rvalid), 32'd0);
    check("t5_stall_clr", 32'(stall_cnt), 32'd0);
    next_cycle();
    p1_req = 0;
    #1;
    check("t5_p1_rvalid", 32'(p1_rvalid), 32'd1);
    check("t5_p1_rdata", p1_rdata, 32'hA5A50030);
    check("t5_stall_zero", 32'(stall_cnt), 32'd0);

    // 6: saturation under sustained contention
    next_cycle(); rst = 1;
    next_cycle(); rst = 0;
    p0_req = 1; p1_req = 1;
    for (int i = 0; i < 65540; i++) next_cycle();
    #1;
    check("t6_stall_sat", 32'(stall_cnt), 32'hFFFF);
    next_cycle(); next_cycle();
    p0_req = 0; p1_req = 0;
    #1;
    check("t6_stall_hold", 32'(stall_cnt), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
